sf2_ram_port_arbiter: RTL

//  Shares one RAM1K18 port (port A, 18-bit width mode) between NREQ requesters.

---
 rtl/sf2_ram_port_arbiter_pkg.sv | 15 +
 rtl/sf2_rr_arbiter.sv | 47 ++++
 rtl/sf2_ram_port_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sf2_ram_port_arbiter_pkg.sv
// Shared definitions for the RAM1K18 port-A arbiter: data width, byte-enable
// encodings and the init/run FSM states.
package sf2_ram_port_arbiter_pkg;

  localparam int DATA_W = 18;

  localparam logic [1:0] WEN_WRITE = 2'b11;
  localparam logic [1:0] WEN_READ  = 2'b00;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sf2_rr_arbiter.sv
// Combinational round-robin pick over NREQ requesters plus the priority
// pointer, which advances past the winner on every grant.
module sf2_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            CLK,
  input  logic            ARST_N,
  input  logic [NREQ-1:0] REQ,
  input  logic            STALL,
  output logic [NREQ-1:0] GNT
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    int idx;
    GNT   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (!STALL) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && REQ[idx]) begin
          found    = 1'b1;
          GNT[idx] = 1'b1;
          win      = PW'(idx);
        end
      end
    end
  end

  // NOTE: combinational blocks use blocking '=', clocked state uses non-blocking '<='.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/sf2_ram_port_arbiter.sv
// Shares RAM1K18 port A between NREQ requesters: clears the memory after reset,
// then grants one access per cycle round-robin and steers read data back by tag.
module sf2_ram_port_arbiter
  import sf2_ram_port_arbiter_pkg::*;
#(
  parameter int                NREQ      = 4,
  parameter int                AW        = 10,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] INIT_WORD = 18'h0
) (
  input  logic                   CLK,
  input  logic                   ARST_N,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        WE,
  input  logic [NREQ*AW-1:0]     ADDR,
  input  logic [NREQ*DATA_W-1:0] WDATA,
  output logic [NREQ-1:0]        GNT,
  output logic [NREQ-1:0]        RVALID,
  output logic [DATA_W-1:0]      RDATA,
  output logic                   INIT_DONE,
  input  logic                   RAM_BUSY,
  output logic                   RAM_EN,
  output logic [1:0]             RAM_WEN,
  output logic [AW-1:0]          RAM_ADDR,
  output logic [DATA_W-1:0]      RAM_DIN,
  input  logic [DATA_W-1:0]      RAM_DOUT
);

  localparam int IW = $clog2(NREQ);

  state_e              state;
  state_e              state_nxt;
  logic [AW-1:0]       cnt;
  logic                stall;
  logic                xfer;
  logic [IW-1:0]       gnt_id;
  logic                sel_we;
  logic [AW-1:0]       sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [RD_LAT:0]     tag_v;
  logic [IW-1:0]       tag_id [RD_LAT+1];

  assign stall = RAM_BUSY || (state != ST_RUN);

  sf2_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .CLK   (CLK),
    .ARST_N(ARST_N),
    .REQ   (REQ),
    .STALL (stall),
    .GNT   (GNT)
  );

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GNT[i]) gnt_id = IW'(i);
    end
    xfer      = |GNT;
    sel_we    = WE[gnt_id];
    sel_addr  = ADDR[int'(gnt_id)*AW +: AW];
    sel_wdata = WDATA[int'(gnt_id)*DATA_W +: DATA_W];
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) state <= ST_INIT;
    else         state <= state_nxt;
  end

  // Leave INIT on the edge that writes the last word.
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && !RAM_BUSY && (&cnt)) state_nxt = ST_RUN;
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      cnt       <= '0;
      INIT_DONE <= 1'b0;
      RAM_EN    <= 1'b0;
      RAM_WEN   <= WEN_READ;
      RAM_ADDR  <= '0;
      RAM_DIN   <= '0;
    end else if (state == ST_INIT) begin
      if (!RAM_BUSY) begin
        RAM_EN   <= 1'b1;
        RAM_WEN  <= WEN_WRITE;
        RAM_ADDR <= cnt;
        RAM_DIN  <= INIT_WORD;
        cnt      <= cnt + 1'b1;
        if (&cnt) INIT_DONE <= 1'b1;
      end else begin
        RAM_EN  <= 1'b0;
        RAM_WEN <= WEN_READ;
      end
    end else begin
      RAM_EN  <= xfer;
      RAM_WEN <= (xfer && sel_we) ? WEN_WRITE : WEN_READ;
      if (xfer)           RAM_ADDR <= sel_addr;
      if (xfer && sel_we) RAM_DIN  <= sel_wdata;
    end
  end

  // Tag valids shift unconditionally so a BUSY stall never drops a read in flight.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) tag_v <= '0;
    else         tag_v <= {tag_v[RD_LAT-1:0], xfer && !sel_we};
  end

  // NOTE: the id payload is qualified by tag_v, so this shift register needs no reset.
  always_ff @(posedge CLK) begin
    tag_id[0] <= gnt_id;
    for (int k = 1; k <= RD_LAT; k++) tag_id[k] <= tag_id[k-1];
  end

  always_comb begin
    RVALID = '0;
    if (tag_v[RD_LAT]) RVALID[tag_id[RD_LAT]] = 1'b1;
  end

  assign RDATA = RAM_DOUT;

endmodule
